conv_out_writeback: RTL and testbench

//  Downstream of the 4-lane 5x5 convolution core. Each out_valid beat carries 4 filtered pixels
//  (lane k = image row r+64k, same column). Beats are buffered in a small FIFO, serialized to one

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_beat_fifo.sv | 69 ++++++
 rtl/conv_out_writeback.sv | 164 ++++++++++++++++
 tb/tb_conv_out_writeback.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and image geometry for the convolution output writeback path.
//   IMG_W, IMG_H : default image size in pixels / rows
//   LANES, PIX_W : pixels per beat and bits per pixel
//   pix_t        : one 8-bit unsigned pixel
//   beat_t       : one core output beat, lane k in bits [8k+7:8k]
//   state_t      : writeback FSM states
// -----------------------------------------------------------------------------
package conv_pkg;
   localparam int IMG_W = 256;
   localparam int IMG_H = 256;
   localparam int LANES = 4;
   localparam int PIX_W = 8;

   typedef logic [PIX_W-1:0]       pix_t;
   typedef logic [LANES*PIX_W-1:0] beat_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/conv_beat_fifo.sv
// -----------------------------------------------------------------------------
// conv_beat_fifo
// Synchronous FIFO of core beats. Each entry carries the beat and its beat
// index (sequence number within the frame) so the drain side can derive the
// SRAM address without its own counter.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop all entries (frame abort)
//   push, push_beat,
//   push_idx             write one beat with its index
//   pop                  retire the head entry
//   head_beat, head_idx  head entry (valid when !empty)
//   full, empty          occupancy flags
// Handshake: a push while full is accepted only when the head is popped in the
// same cycle; the freed slot is the one being written.
// -----------------------------------------------------------------------------
module conv_beat_fifo
   import conv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  beat_t            push_beat,
   input  logic [IDX_W-1:0] push_idx,
   input  logic             pop,
   output beat_t            head_beat,
   output logic [IDX_W-1:0] head_idx,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   beat_t            mem_beat [DEPTH];
   logic [IDX_W-1:0] mem_idx  [DEPTH];
   // Extra MSB on each pointer distinguishes full from empty.
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_beat = mem_beat[rd_ptr[PTR_W-1:0]];
   assign head_idx  = mem_idx[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_beat[wr_ptr[PTR_W-1:0]] <= push_beat;
         mem_idx[wr_ptr[PTR_W-1:0]]  <= push_idx;
      end
   end
endmodule

// File: rtl/conv_out_writeback.sv
// -----------------------------------------------------------------------------
// conv_out_writeback
// Buffers 4-pixel beats from the convolution core, serializes them to one
// pixel per cycle and writes them row-major into the output SRAM. Lane k of
// beat b lands at (b / IMG_W + k*IMG_H/4) * IMG_W + b % IMG_W.
// Optional feature macro: CONV_OUT_CHECKSUM_EN adds the checksum output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         run enable, held high for a whole frame
//   in_valid      beat valid from the core (one beat per high cycle)
//   in_pix        beat pixels, lane 0 in [7:0]
//   in_ready      beat can be accepted this cycle (combinational)
//   wr_en         SRAM write strobe (registered)
//   wr_addr       SRAM write address (registered, holds when idle)
//   wr_data       SRAM write data (registered, holds when idle)
//   done          frame complete, held until start drops
//   state         current FSM state (debug visibility)
//   overflow      sticky: a beat arrived in RUN and was dropped
//   checksum      sum of written pixels (CONV_OUT_CHECKSUM_EN only)
// Handshake: a beat transfers when in_valid && in_ready at a rising edge and
// the frame still expects beats; in_valid without a transfer in RUN is a drop.
// -----------------------------------------------------------------------------
module conv_out_writeback
   import conv_pkg::*;
#(
   parameter int IMG_W      = conv_pkg::IMG_W,
   parameter int IMG_H      = conv_pkg::IMG_H,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  beat_t             in_pix,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output pix_t              wr_data,
   output logic              done,
   output state_t            state,
   output logic              overflow
`ifdef CONV_OUT_CHECKSUM_EN
   ,
   output logic [23:0]       checksum
`endif
);
   localparam int IDX_W = ADDR_W - 2;
   localparam int BEATS = IMG_W * IMG_H / 4;
   localparam logic [IDX_W:0]    BEATS_L     = (IDX_W+1)'(BEATS);
   localparam logic [ADDR_W:0]   PIX_TOTAL   = (ADDR_W+1)'(IMG_W * IMG_H);
   // Lane k sits IMG_H/4 rows below lane 0: (IMG_H/4)*IMG_W == BEATS pixels.
   localparam logic [ADDR_W-1:0] LANE_STRIDE = ADDR_W'(BEATS);

   logic [IDX_W:0]    beat_cnt;
   logic [1:0]        lane;
   logic [ADDR_W:0]   pix_cnt;
   beat_t             head_beat;
   logic [IDX_W-1:0]  head_idx;
   logic              full;
   logic              empty;
   logic              run;
   logic              pop_last;
   logic              drain;
   logic              push;
   logic              drop;
   logic              flush;
   pix_t              head_pix;
   logic [ADDR_W-1:0] lane_off;

   assign run      = (state == RUN);
   // pop_last is the slot-freeing condition used by in_ready; the actual pop
   // is additionally gated by start so an aborting frame issues no write.
   assign pop_last = run && !empty && (lane == 2'd3);
   assign drain    = run && start && !empty;
   assign in_ready = run && (!full || pop_last);
   assign push     = in_valid && in_ready && (beat_cnt < BEATS_L);
   assign drop     = in_valid && run && !push;
   assign flush    = run && !start;
   assign head_pix = head_beat[lane*PIX_W +: PIX_W];
   // row*IMG_W + col of beat b is b itself, so only the lane offset is added.
   assign lane_off = ADDR_W'(lane) * LANE_STRIDE;

   conv_beat_fifo #(
      .DEPTH (FIFO_DEPTH),
      .IDX_W (IDX_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_beat (in_pix),
      .push_idx  (beat_cnt[IDX_W-1:0]),
      .pop       (drain && (lane == 2'd3)),
      .head_beat (head_beat),
      .head_idx  (head_idx),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
         lane     <= '0;
         pix_cnt  <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
`ifdef CONV_OUT_CHECKSUM_EN
         checksum <= '0;
`endif
      end else begin
         wr_en <= drain;
         if (drain) begin
            wr_addr <= ADDR_W'(head_idx) + lane_off;
            wr_data <= head_pix;
            lane    <= lane + 2'd1;
            pix_cnt <= pix_cnt + 1'b1;
`ifdef CONV_OUT_CHECKSUM_EN
            checksum <= checksum + 24'(head_pix);
`endif
         end
         if (push) beat_cnt <= beat_cnt + 1'b1;
         if (drop) overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  beat_cnt <= '0;
                  lane     <= '0;
                  pix_cnt  <= '0;
                  overflow <= 1'b0;
`ifdef CONV_OUT_CHECKSUM_EN
                  checksum <= '0;
`endif
               end
            end
            RUN: begin
               if (!start) begin
                  state <= IDLE;
                  lane  <= '0;
               end else if ((pix_cnt == PIX_TOTAL) && empty) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (!start) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conv_out_writeback.sv
// -----------------------------------------------------------------------------
// tb_conv_out_writeback
// Bench for conv_out_writeback. A behavioural model holds the expected pixel
// stream as a queue of (address, data) entries: every accepted beat appends
// its four pixels, one entry leaves per cycle while the frame runs. Outputs
// are compared against the model on every falling edge; directed sections
// add literal expectations. CONV_OUT_CHECKSUM_EN also checks checksum.
// -----------------------------------------------------------------------------
module tb_conv_out_writeback;
   import conv_pkg::*;

   localparam int DEPTH  = 4;
   localparam int NPIX   = 65536;
   localparam int NBEATS = 16384;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pix = '0;
   logic        in_ready;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        done;
   state_t      state;
   logic        overflow;
`ifdef CONV_OUT_CHECKSUM_EN
   logic [23:0] checksum;
`endif

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   conv_out_writeback dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_pix   (in_pix),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .done     (done),
      .state    (state),
      .overflow (overflow)
`ifdef CONV_OUT_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   state_t      m_state = IDLE;
   logic [23:0] exp_q[$];          // {addr[15:0], data[7:0]} in write order
   int          m_beat_cnt = 0;
   int          m_pix_cnt = 0;
   bit          m_ovf = 1'b0;
   logic        m_wr_en = 1'b0;
   logic [15:0] m_addr = '0;
   logic [7:0]  m_data = '0;
   int          m_sum = 0;
   bit          m_take;
   bit          m_fin;
   logic [23:0] m_e;

   // Beats held = pixels outstanding rounded up to whole beats; one pixel left
   // means the head beat's last lane leaves this cycle.
   function automatic bit model_ready();
      return (m_state == RUN) &&
             ((((exp_q.size() + 3) / 4) < DEPTH) || ((exp_q.size() % 4) == 1));
   endfunction

   task automatic model_push(input int b, input logic [31:0] pix);
      int row, col, addr;
      row = b / 256;
      col = b % 256;
      for (int k = 0; k < 4; k++) begin
         addr = (row + k * 64) * 256 + col;
         exp_q.push_back({addr[15:0], pix[8*k +: 8]});
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_state = IDLE; exp_q.delete(); m_beat_cnt = 0; m_pix_cnt = 0;
         m_ovf = 1'b0; m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_sum = 0;
      end else begin
         case (m_state)
            IDLE: begin
               m_wr_en = 1'b0;
               if (start) begin
                  m_state = RUN; m_beat_cnt = 0; m_pix_cnt = 0; m_ovf = 1'b0; m_sum = 0;
               end
            end
            RUN: begin
               m_take = in_valid && model_ready() && (m_beat_cnt < NBEATS);
               if (in_valid && !m_take) m_ovf = 1'b1;
               if (!start) begin
                  m_state = IDLE; exp_q.delete(); m_wr_en = 1'b0;
               end else begin
                  m_fin = (m_pix_cnt == NPIX) && (exp_q.size() == 0);
                  if (exp_q.size() > 0) begin
                     m_e = exp_q.pop_front();
                     m_wr_en = 1'b1; m_addr = m_e[23:8]; m_data = m_e[7:0];
                     m_pix_cnt++; m_sum += int'(m_e[7:0]);
                  end else begin
                     m_wr_en = 1'b0;
                  end
                  if (m_take) begin
                     model_push(m_beat_cnt, in_pix);
                     m_beat_cnt++;
                  end
                  if (m_fin) m_state = DONE;
               end
            end
            DONE: begin
               m_wr_en = 1'b0;
               if (!start) m_state = IDLE;
            end
            default: m_state = IDLE;
         endcase
      end
   end

   // ---------------- scoreboard compare ----------------
   byte unsigned hits[NPIX];
   int           wr_seen = 0;

   always @(negedge clk) begin
      if (chk_on) begin
         check("wr_en", 32'(wr_en), 32'(m_wr_en));
         check("wr_addr", 32'(wr_addr), 32'(m_addr));
         check("wr_data", 32'(wr_data), 32'(m_data));
         check("done", 32'(done), 32'(m_state == DONE));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("state", 32'(state), 32'(m_state));
         check("in_ready", 32'(in_ready), 32'(model_ready()));
`ifdef CONV_OUT_CHECKSUM_EN
         check("checksum", 32'(checksum), 32'(m_sum[23:0]));
`endif
         if (wr_en === 1'b1) begin
            hits[wr_addr] = hits[wr_addr] + 8'd1;
            wr_seen++;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic restart();
      start = 1'b0; tick();
      start = 1'b1; tick();
   endtask

   int          accepted;
   int          cycles;
   int          w0;
   int          bad;
   logic [7:0]  bb;

   initial begin
      // Reset state
      rst = 1'b1; tick(); chk_on = 1'b1; tick();
      rst = 1'b0; start = 1'b1; tick();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_pix = $urandom; tick();
      end
      in_valid = 1'b0; rst = 1'b1; tick(); tick();
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      rst = 1'b0; tick();
      check("post_rst_wr_en", 32'(wr_en), 32'd0);
      tick();
      check("post_rst_wr_en2", 32'(wr_en), 32'd0);

      // Single beat at b=0
      in_valid = 1'b1; in_pix = 32'h44332211; tick();
      in_valid = 1'b0;
      check("lat_t_wr_en", 32'(wr_en), 32'd0);
      tick();
      check("beat_l0", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b1, 16'd0, 8'h11});
      tick();
      check("beat_l1", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b1, 16'd16384, 8'h22});
      tick();
      check("beat_l2", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b1, 16'd32768, 8'h33});
      tick();
      check("beat_l3", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b1, 16'd49152, 8'h44});
      tick();
      check("beat_after", {7'd0, wr_en, wr_addr, wr_data}, {7'd0, 1'b0, 16'd49152, 8'h44});

      // Burst of 6 back-to-back beats; the 5th lands on the head's last lane
      restart();
      w0 = wr_seen;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_pix = $urandom;
         #1;
         check($sformatf("burst_ready_%0d", i), 32'(in_ready), 32'(i < 5));
         @(posedge clk); #1;
      end
      in_valid = 1'b0; tick();
      check("burst_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 25; i++) tick();
      check("burst_writes", 32'(wr_seen - w0), 32'd20);

      // Random stream then abort around b=100
      restart();
      accepted = 0; cycles = 0;
      while (accepted < 95 && cycles < 3000) begin
         in_valid = ($urandom_range(0, 2) == 0); in_pix = $urandom;
         @(negedge clk);
         if (in_valid && in_ready) accepted++;
         tick();
         cycles++;
      end
      check("stream_budget", 32'(cycles < 3000), 32'd1);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_pix = $urandom; tick();
      end
      in_valid = 1'b0;
      check("stream_overflow", 32'(overflow), 32'd1);
      start = 1'b0; tick();
      check("abort_state", 32'(state), 32'(IDLE));
      w0 = wr_seen;
      for (int i = 0; i < 20; i++) tick();
      check("abort_no_writes", 32'(wr_seen - w0), 32'd0);
      start = 1'b1; tick();
      check("restart_overflow", 32'(overflow), 32'd0);
      check("restart_state", 32'(state), 32'(RUN));

      // Full frame, one beat every 4 cycles, pixel = b[7:0] on every lane
      for (int a = 0; a < NPIX; a++) hits[a] = 8'd0;
      w0 = wr_seen;
      for (int b = 0; b < NBEATS; b++) begin
         bb = b[7:0];
         in_valid = 1'b1; in_pix = {4{bb}}; tick();
         in_valid = 1'b0; tick(); tick(); tick();
      end
      cycles = 0;
      while (done !== 1'b1 && cycles < 20) begin
         tick();
         cycles++;
      end
      check("frame_done", 32'(done), 32'd1);
      check("frame_overflow", 32'(overflow), 32'd0);
      check("frame_writes", 32'(wr_seen - w0), 32'd65536);
      bad = 0;
      for (int a = 0; a < NPIX; a++) if (hits[a] != 8'd1) bad++;
      check("frame_addr_once", 32'(bad), 32'd0);
`ifdef CONV_OUT_CHECKSUM_EN
      check("frame_checksum", 32'(checksum), 32'd8355840);
`endif
      // Beats in DONE are ignored without a flag
      in_valid = 1'b1; in_pix = $urandom; tick();
      in_valid = 1'b0; tick();
      check("done_ignore_overflow", 32'(overflow), 32'd0);
      check("done_held", 32'(done), 32'd1);
      start = 1'b0; tick();
      check("done_release", 32'(done), 32'd0);
      check("done_release_state", 32'(state), 32'(IDLE));
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
